s2p_symbol_packer: RTL
======================

S2P_SYMBOL_PACKER -- requirements
Module: s2p_symbol_packer

Interface
REQ-001 SHALL have parameter BITS_PER_SYM, default 2, bits per QAM symbol; even, 2..8.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in symbol MSB, 0 = in LSB.
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  1  serial data bit, sampled only when data_change=1.
REQ-006 SHALL have port data_change  input  1  bit strobe; one bit accepted per high cycle.
REQ-007 SHALL have port sym_sync  input  1  frame alignment; marks the start of a new symbol.
REQ-008 SHALL have port symbol  output  BITS_PER_SYM  last completed raw symbol.
REQ-009 SHALL have port sym_i  output  BITS_PER_SYM/2  in-phase half, upper half of symbol (mapped per REQ-024).
REQ-010 SHALL have port sym_q  output  BITS_PER_SYM/2  quadrature half, lower half of symbol (mapped per REQ-024).
REQ-011 SHALL have port symbol_valid  output  1  one-cycle pulse on each new symbol.
REQ-012 SHALL have port bit_cnt  output  clog2(BITS_PER_SYM)  bits accepted into the current partial symbol.

Function
REQ-013 SHALL, on data_change=1, shift data_in into the shift register:
- MSB_FIRST=1: shift left, new bit at LSB.
- MSB_FIRST=0: shift right, new bit at MSB.
REQ-014 SHALL increment bit_cnt on each accepted bit, wrapping from BITS_PER_SYM-1 to 0.
REQ-015 SHALL, when data_change=1 and bit_cnt=BITS_PER_SYM-1 (last bit):
- load symbol with the completed word including the current bit;
- register symbol_valid=1 on that same clock edge.
REQ-016 SHALL hold symbol_valid high exactly one cycle per symbol.
REQ-017 SHALL hold symbol, sym_i and sym_q stable between completions.
REQ-018 SHALL accept data_change high on consecutive cycles: one bit per cycle, no lost bits, back-to-back valid pulses BITS_PER_SYM cycles apart.
REQ-019 SHALL, on sym_sync=1 with data_change=1:
- discard the partial symbol;
- take data_in as bit 0 of a new symbol;
- set bit_cnt to 1.
REQ-020 SHALL, on sym_sync=1 with data_change=0, clear the partial symbol and set bit_cnt to 0; symbol is held.
REQ-021 SHALL give sym_sync priority over completion: when sym_sync coincides with a last bit, no symbol_valid is produced and symbol is unchanged.
REQ-022 SHALL leave all state unchanged when data_change=0 and sym_sync=0.

Reset
REQ-023 SHALL, when reset=1 at a clock edge, clear to 0 and override all other inputs, including mid-symbol:
- shift register, bit_cnt, symbol, sym_i, sym_q, symbol_valid.

Configuration
REQ-024 SHALL honour macro S2P_GRAY_MAP_EN:
- defined: sym_i = Ih ^ (Ih>>1) and sym_q = Qh ^ (Qh>>1), where Ih and Qh are the upper and lower halves of symbol;
- undefined: sym_i = Ih and sym_q = Qh;
- symbol stays raw and latency is identical in both cases.

Structure
REQ-025 SHALL place the following in shared package qam_pkg:
- constants BPS_MIN=2 and BPS_MAX=8;
- the clog2 function;
- the binary-to-Gray function.
REQ-026 SHALL use one sub-module, s2p_gray_enc: combinational, width BITS_PER_SYM/2, instantiated once for I and once for Q.
REQ-027 SHALL, with BITS_PER_SYM=2 and MSB_FIRST=1, behave as the existing 2-bit serial-to-parallel converter, plus symbol_valid.

Verification
REQ-028 SHALL cover: BITS_PER_SYM=4, MSB_FIRST=1, bits 1,0,1,1 -> symbol=4'b1011, sym_i=2'b10, sym_q=2'b11, symbol_valid for one cycle at the 4th strobe edge.
REQ-029 SHALL cover: same stimulus with S2P_GRAY_MAP_EN -> sym_i=2'b11, sym_q=2'b10, symbol=4'b1011.
REQ-030 SHALL cover: MSB_FIRST=0, bits 1,0,1,1 -> symbol=4'b1101.
REQ-031 SHALL cover: bits 1,0, then sym_sync with bit 1, then bits 1,0,0 -> no valid before the sync, then symbol=4'b1100 at the 4th post-sync bit.
REQ-032 SHALL cover: data_change high for 8 consecutive cycles -> two symbol_valid pulses 4 cycles apart.
REQ-033 SHALL cover: reset after 3 bits, then bits 0,1,1,0 -> all outputs 0 during reset, then symbol=4'b0110 with no stale bits.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared constants and helpers for the QAM symbol path: legal bits-per-symbol
// range, a constant clog2 and a binary-to-Gray conversion.
package qam_pkg;

    localparam int BPS_MIN = 2;
    localparam int BPS_MAX = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Zero-extended inputs give the same low Gray bits as the narrow value.
    function automatic logic [BPS_MAX-1:0] bin2gray(input logic [BPS_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/s2p_gray_enc.sv
// Combinational binary-to-Gray encoder for one half (I or Q) of a QAM symbol.
module s2p_gray_enc
    import qam_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = W'(bin2gray(BPS_MAX'(bin)));

endmodule

// File: rtl/s2p_symbol_packer.sv
// Serial-to-parallel QAM symbol packer with frame alignment and one-cycle valid pulse.
// Define S2P_GRAY_MAP_EN to Gray-map the I/Q halves; symbol itself always stays raw.
module s2p_symbol_packer
    import qam_pkg::*;
#(
    parameter int BITS_PER_SYM = 2,
    parameter int MSB_FIRST    = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             data_in,
    input  logic                             data_change,
    input  logic                             sym_sync,
    output logic [BITS_PER_SYM-1:0]          symbol,
    output logic [BITS_PER_SYM/2-1:0]        sym_i,
    output logic [BITS_PER_SYM/2-1:0]        sym_q,
    output logic                             symbol_valid,
    output logic [clog2(BITS_PER_SYM)-1:0]   bit_cnt
);

    localparam int H  = BITS_PER_SYM / 2;
    localparam int CW = clog2(BITS_PER_SYM);
    localparam logic [CW-1:0] LAST = CW'(BITS_PER_SYM - 1);

    logic [BITS_PER_SYM-1:0] shreg;
    logic [BITS_PER_SYM-1:0] shifted;
    logic [BITS_PER_SYM-1:0] fresh;
    logic                    complete;

    // fresh is the register image after a sync strobe: only the first bit present.
    always_comb begin
        shifted = '0;
        fresh   = '0;
        if (MSB_FIRST != 0) begin
            shifted = {shreg[BITS_PER_SYM-2:0], data_in};
            fresh   = {{(BITS_PER_SYM-1){1'b0}}, data_in};
        end else begin
            shifted = {data_in, shreg[BITS_PER_SYM-1:1]};
            fresh   = {data_in, {(BITS_PER_SYM-1){1'b0}}};
        end
    end

    assign complete = data_change && !sym_sync && (bit_cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            symbol       <= '0;
            symbol_valid <= 1'b0;
        end else begin
            symbol_valid <= complete;
            if (sym_sync) begin
                shreg   <= data_change ? fresh : '0;
                bit_cnt <= data_change ? CW'(1) : '0;
            end else if (data_change) begin
                shreg   <= shifted;
                bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
                if (complete) begin
                    symbol <= shifted;
                end
            end
        end
    end

`ifdef S2P_GRAY_MAP_EN
    s2p_gray_enc #(.W(H)) u_gray_i (
        .bin  (symbol[BITS_PER_SYM-1:H]),
        .gray (sym_i)
    );

    s2p_gray_enc #(.W(H)) u_gray_q (
        .bin  (symbol[H-1:0]),
        .gray (sym_q)
    );
`else
    assign sym_i = symbol[BITS_PER_SYM-1:H];
    assign sym_q = symbol[H-1:0];
`endif

endmodule
